// File: rtl/md_issue_ctrl_if.sv
// Bus between D-stage decode, the MDU and the MD issue/hazard controller.
// The controller takes the slave side; decode/MDU (or a bench) take the master side.
interface md_issue_ctrl_if #(
  parameter int CNT_W = 4
);
  // Handshake: D holds an MD-class instruction (d_valid && d_md_op in 1..8)
  // until a cycle with stall_md=0 and ext_stall=0; that edge is its transfer
  // into E. stall_md never depends on ext_stall, so there is no loop back.
  logic             d_valid;
  logic [3:0]       d_md_op;
  logic             ext_stall;
  logic             mdu_busy;
  logic [3:0]       e_op;
  logic             e_start;
  logic             stall_md;
  logic             shadow_busy;
  logic [31:0]      stall_cnt;
  logic [1:0]       dbg_state;
  logic [CNT_W-1:0] dbg_cnt;

  modport slave (
    input  d_valid, d_md_op, ext_stall, mdu_busy,
    output e_op, e_start, stall_md, shadow_busy, stall_cnt, dbg_state, dbg_cnt
  );

  modport master (
    output d_valid, d_md_op, ext_stall, mdu_busy,
    input  e_op, e_start, stall_md, shadow_busy, stall_cnt, dbg_state, dbg_cnt
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// E-stage issue and hazard control for the multiply/divide unit: registers the
// MD op into E, shadows MDU latency and stalls dependent MD ops in D.
module md_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic         clk,
  input  logic         reset,
  md_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       e_op_q;
  logic             e_start_q;
  logic [31:0]      stall_cnt_q;

  logic [3:0]       op_norm;
  logic             md_class;
  logic             is_start;
  logic             stall;
  logic             bubble;

  // Encodings 9..15 decode as "no MD op" so they never stall or issue.
  always_comb begin
    op_norm  = (bus.d_md_op <= 4'd8) ? bus.d_md_op : 4'd0;
    md_class = bus.d_valid && (op_norm != 4'd0);
    is_start = (op_norm >= 4'd1) && (op_norm <= 4'd4);
    stall    = md_class && (e_start_q || (state != IDLE) || bus.mdu_busy);
    bubble   = stall || bus.ext_stall || !bus.d_valid;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (e_start_q && (e_op_q == 4'd1 || e_op_q == 4'd2)) begin
          state_nxt = MULT;
          cnt_nxt   = CNT_W'(1);
        end else if (e_start_q && (e_op_q == 4'd3 || e_op_q == 4'd4)) begin
          state_nxt = DIV;
          cnt_nxt   = CNT_W'(1);
        end
      end
      MULT: begin
        if (cnt == CNT_W'(MULT_LAT)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DIV: begin
        if (cnt == CNT_W'(DIV_LAT)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      e_op_q      <= 4'd0;
      e_start_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (bubble) begin
        e_op_q    <= 4'd0;
        e_start_q <= 1'b0;
      end else begin
        e_op_q    <= op_norm;
        e_start_q <= is_start;
      end
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.e_op        = e_op_q;
  assign bus.e_start     = e_start_q;
  assign bus.stall_md    = stall;
  assign bus.shadow_busy = (state != IDLE);
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.dbg_state   = state;
  assign bus.dbg_cnt     = cnt;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: hand vector table, multi-cycle corner sequences and
// random traffic, all checked against a countdown-based reference model.
module tb_md_issue_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk = 1'b0;
  logic reset;

  md_issue_ctrl_if #(.CNT_W(4)) bus ();

  md_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: E register, remaining busy cycles, stall counter.
  logic [3:0]  m_e_op    = 4'd0;
  logic        m_e_start = 1'b0;
  int          m_busy    = 0;
  logic [31:0] m_cnt     = 32'd0;

  // DUT outputs sampled mid-cycle by the last call to cycle().
  logic [3:0]  o_eop;
  logic        o_est, o_stall, o_sh;
  logic [31:0] o_cnt;
  logic [1:0]  o_state;
  logic [3:0]  o_dcnt;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  // Apply one cycle of inputs, optionally compare with the model, then advance.
  task automatic cycle(input logic r, input logic v, input logic [3:0] op,
                       input logic es, input logic mb, input bit check);
    logic md, x_stall;
    int lat;
    reset         = r;
    bus.d_valid   = v;
    bus.d_md_op   = op;
    bus.ext_stall = es;
    bus.mdu_busy  = mb;
    md      = v && (op >= 4'd1) && (op <= 4'd8);
    x_stall = md && (m_e_start || (m_busy > 0) || mb);
    @(negedge clk);
    o_eop   = bus.e_op;
    o_est   = bus.e_start;
    o_stall = bus.stall_md;
    o_sh    = bus.shadow_busy;
    o_cnt   = bus.stall_cnt;
    o_state = bus.dbg_state;
    o_dcnt  = bus.dbg_cnt;
    if (check) begin
      chk("e_op",        32'(o_eop),   32'(m_e_op));
      chk("e_start",     32'(o_est),   32'(m_e_start));
      chk("stall_md",    32'(o_stall), 32'(x_stall));
      chk("shadow_busy", 32'(o_sh),    32'(m_busy > 0));
      chk("stall_cnt",   o_cnt,        m_cnt);
    end
    @(posedge clk);
    if (r) begin
      m_e_op = 4'd0; m_e_start = 1'b0; m_busy = 0; m_cnt = 32'd0;
    end else begin
      lat = (m_e_op <= 4'd2) ? MULT_LAT : DIV_LAT;
      if (m_e_start) m_busy = lat;
      else if (m_busy > 0) m_busy = m_busy - 1;
      if (x_stall) m_cnt = m_cnt + 32'd1;
      if (x_stall || es || !v) begin
        m_e_op = 4'd0; m_e_start = 1'b0;
      end else begin
        m_e_op    = md ? op : 4'd0;
        m_e_start = md && (op <= 4'd4);
      end
    end
    #1;
  endtask

  typedef struct {
    logic        r, v;
    logic [3:0]  op;
    logic        es, mb;
    logic [3:0]  x_eop;
    logic        x_est, x_stall, x_sh;
    logic [31:0] x_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic v, logic [3:0] op, logic es, logic mb,
                              logic [3:0] x_eop, logic x_est, logic x_stall,
                              logic x_sh, logic [31:0] x_cnt);
    vec_t t;
    t.r = r; t.v = v; t.op = op; t.es = es; t.mb = mb;
    t.x_eop = x_eop; t.x_est = x_est; t.x_stall = x_stall; t.x_sh = x_sh; t.x_cnt = x_cnt;
    tbl.push_back(t);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls, shc;
    logic [31:0] base;

    // Post-reset state, then mult followed by a dependent mflo.
    add(0,0,0,0,0, 0,0,0,0,0);
    add(0,1,1,0,0, 0,0,0,0,0);
    add(0,1,7,0,0, 1,1,1,0,0);
    for (int k = 1; k <= 5; k++) add(0,1,7,0,0, 0,0,1,1,32'(k));
    add(0,1,7,0,0, 0,0,0,0,6);
    add(0,0,0,0,0, 7,0,0,0,6);
    // mthi, mtlo, mfhi back to back with the MDU idle.
    add(0,1,6,0,0, 0,0,0,0,6);
    add(0,1,5,0,0, 6,0,0,0,6);
    add(0,1,8,0,0, 5,0,0,0,6);
    add(0,0,0,0,0, 8,0,0,0,6);
    // div held in D under ext_stall, then released.
    for (int k = 0; k < 3; k++) add(0,1,3,1,0, 0,0,0,0,6);
    add(0,1,3,0,0, 0,0,0,0,6);
    add(0,0,0,0,0, 3,1,0,0,6);
    add(0,0,0,0,0, 0,0,0,1,6);

    reset = 1'b1;
    bus.d_valid = 1'b1; bus.d_md_op = 4'd1; bus.ext_stall = 1'b0; bus.mdu_busy = 1'b0;
    #1;
    cycle(1, 1, 4'd1, 0, 0, 0);
    cycle(1, 1, 4'd1, 0, 0, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].op, tbl[i].es, tbl[i].mb, 1);
      chk($sformatf("tbl%0d_e_op", i),     32'(o_eop),   32'(tbl[i].x_eop));
      chk($sformatf("tbl%0d_e_start", i),  32'(o_est),   32'(tbl[i].x_est));
      chk($sformatf("tbl%0d_stall", i),    32'(o_stall), 32'(tbl[i].x_stall));
      chk($sformatf("tbl%0d_shadow", i),   32'(o_sh),    32'(tbl[i].x_sh));
      chk($sformatf("tbl%0d_stall_cnt", i), o_cnt,       tbl[i].x_cnt);
    end

    // Let the div from the table drain.
    for (int k = 0; k < 12; k++) cycle(0, 0, 4'd0, 0, m_busy > 0, 1);

    // divu then a dependent mfhi held in D until released.
    base = m_cnt;
    cycle(0, 1, 4'd4, 0, m_busy > 0, 1);
    stalls = 0; shc = 0;
    for (int k = 0; k < 30; k++) begin
      cycle(0, 1, 4'd8, 0, m_busy > 0, 1);
      if (o_stall) stalls++;
      if (o_sh) shc++;
      if (!o_stall) break;
    end
    chk("divu_stall_cycles",  32'(stalls), 32'd11);
    chk("divu_shadow_cycles", 32'(shc),    32'd10);
    cycle(0, 0, 4'd0, 0, m_busy > 0, 1);
    chk("divu_mfhi_e_op", 32'(o_eop), 32'd8);
    chk("divu_stall_cnt", o_cnt, base + 32'd11);

    // Reset four cycles into a div count, with a mult waiting in D.
    cycle(0, 1, 4'd3, 0, 0, 1);
    for (int k = 0; k < 4; k++) cycle(0, 0, 4'd0, 0, m_busy > 0, 1);
    chk("rst_mid_busy_before", 32'(o_sh), 32'd1);
    cycle(0, 0, 4'd0, 0, m_busy > 0, 1);
    chk("rst_mid_cnt_before", 32'(o_dcnt), 32'd4);
    cycle(1, 1, 4'd1, 0, 1, 1);
    cycle(0, 1, 4'd1, 0, 0, 1);
    chk("rst_mid_shadow", 32'(o_sh),    32'd0);
    chk("rst_mid_state",  32'(o_state), 32'd0);
    chk("rst_mid_cnt",    32'(o_dcnt),  32'd0);
    chk("rst_mid_e_start", 32'(o_est),  32'd0);
    cycle(0, 0, 4'd0, 0, 0, 1);
    chk("rst_mult_e_start", 32'(o_est), 32'd1);
    chk("rst_mult_e_op",    32'(o_eop), 32'd1);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic r, v, es, mb;
      logic [3:0] op;
      r  = ($urandom_range(0, 49) == 0);
      v  = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      es = ($urandom_range(0, 4) == 0);
      mb = (m_busy > 0) || ($urandom_range(0, 19) == 0);
      cycle(r, v, op, es, mb, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- E-stage issue and hazard controller for the multiply/divide unit (MDU) in the P6 pipeline.
- Sits between D-stage decode and the MDU.
- Registers the D-stage mult/div class op into E, and generates the MDU `start`/`op` pair.
- Keeps a shadow latency counter matching MDU timing, and raises a stall for any D-stage MD-class instruction while the MDU is, or is about to be, busy. Also keeps a stall performance counter.

Parameters:
- MULT_LAT, 5, busy cycles following a mult/multu start cycle.
- DIV_LAT, 10, busy cycles following a div/divu start cycle.
- CNT_W, 4, width of the shadow latency counter; must hold DIV_LAT.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high.
- d_valid  in  1  D-stage instruction valid.
- d_md_op  in  4  D-stage MD class: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi, 7 mflo, 8 mfhi; 9-15 treated as 0.
- ext_stall  in  1  stall from other hazard sources; forces E bubble.
- mdu_busy  in  1  busy flag returned by the MDU.
- e_op  out  4  registered op to MDU.
- e_start  out  1  registered start to MDU; high only for ops 1-4.
- stall_md  out  1  combinational MD stall to D/F stages.
- shadow_busy  out  1  shadow counter active (state != IDLE).
- stall_cnt  out  32  count of cycles with stall_md=1.

Behaviour:
Reset (synchronous, active-high, on clk rising edge):
- e_op=0, e_start=0, state=IDLE, cnt=0, stall_cnt=0.
- Reset mid-operation aborts the shadow count immediately. Next cycle is IDLE regardless of prior state.

Op decode:
- md_class = d_valid && d_md_op in 1..8.
- is_start = d_md_op in 1..4.

stall_md (combinational):
- stall_md = md_class && (e_start || state != IDLE || mdu_busy).
- mdu_busy is ORed in as a safety net; the shadow counter alone must already cover it.

E register, each cycle when not in reset:
- If stall_md || ext_stall || !d_valid: e_op<=0, e_start<=0 (bubble).
- Else: e_op<=d_md_op (0 if out of range), e_start<=is_start.
- Never holds a value for two cycles. A start pulse is exactly one cycle wide.

Shadow FSM, states IDLE / MULT / DIV:
- IDLE: if e_start && e_op in {1,2} -> MULT, cnt<=1. If e_start && e_op in {3,4} -> DIV, cnt<=1.
- MULT: if cnt==MULT_LAT -> IDLE, cnt<=0; else cnt<=cnt+1.
- DIV: if cnt==DIV_LAT -> IDLE, cnt<=0; else cnt<=cnt+1.
- A start is never issued while state != IDLE; this is guaranteed by stall_md.

Timing contract:
- For a start in cycle T, shadow_busy is high in cycles T+1 .. T+MULT_LAT (mult) or T+1 .. T+DIV_LAT (div).
- MDU busy over the same window.
- A dependent MD op in D is released in cycle T+MULT_LAT+1 and enters E at the next edge.

Non-MD instructions (d_md_op=0) are never stalled by this block.

mtlo/mthi/mflo/mfhi:
- Issue with e_start=0.
- Stall only behind a busy MDU or a same-cycle E start.
- Back-to-back non-busy MD ops issue at one per cycle.

Simultaneous events:
- ext_stall together with a start-class op in D: bubble, no start, no FSM change.
- stall_md and ext_stall both high: bubble.

stall_cnt:
- Increments by 1 on every cycle with stall_md=1; wraps from 0xFFFFFFFF to 0.
- Unaffected by ext_stall alone.

Test Plan:
1. Reset for 2 cycles with d_valid=1, d_md_op=1 -> e_op=0, e_start=0, shadow_busy=0, stall_cnt=0.
2. mult in D at cycle 0 then mflo held in D -> e_start=1, e_op=1 at cycle 1; stall_md=1 for cycles 1-6; mflo enters E (e_op=7, e_start=0) at cycle 7; stall_cnt=6.
3. divu at cycle 0 followed by mfhi -> shadow_busy high cycles 2-11; stall_md high cycles 1-11; e_op=8 at cycle 12; stall_cnt=11.
4. mthi, mtlo, mfhi on consecutive cycles with MDU idle -> e_op sequence 6,5,8; e_start=0 throughout; stall_md never asserts.
5. ext_stall=1 for 3 cycles while div sits in D -> e_op=0 during those cycles, no start, FSM stays IDLE; on release, e_start=1, e_op=3.
6. Assert reset at cycle 4 of a div count -> next cycle state=IDLE, shadow_busy=0; a new mult in D issues on the following edge with e_start=1.
